// File: rtl/delay_tdc_pkg.sv
// Shared types and elaboration helpers for the delay-line TDC sensor.
package delay_tdc_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_CAPTURE = 3'd2,
    S_ENCODE  = 3'd3,
    S_ACCUM   = 3'd4,
    S_DONE    = 3'd5
  } tdc_state_e;

  // Taps must sit an even number of inversions apart so every tap shares the
  // launch polarity once the edge has passed it.
  localparam int unsigned STAGE_PARITY_MASK = 32'd1;

  function automatic bit stages_are_even(input int unsigned stages);
    return (stages != 0) && ((stages & STAGE_PARITY_MASK) == 0);
  endfunction

endpackage

// File: rtl/delay_tdc_sensor_delay_line.sv
// Kept inverter chain for the TDC. Tap k is the output of stage
// (k+1)*STAGES_PER_TAP-1, so it carries the launch level once the edge arrives.
module tdc_delay_line #(
  parameter int NUM_TAPS       = 64,
  parameter int STAGES_PER_TAP = 2
) (
  input  logic                launch_i,
  output logic [NUM_TAPS-1:0] taps_o
);

  localparam int NUM_STAGES = NUM_TAPS * STAGES_PER_TAP;

  // One separately named net per stage so nothing folds the chain away.
  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    (* keep = "true" *) logic inv_out;
    if (i == 0) begin : g_first
      assign inv_out = ~launch_i;
    end else begin : g_next
      assign inv_out = ~g_stage[i-1].inv_out;
    end
  end

  // Pick off every STAGES_PER_TAP-th stage as a tap.
  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    assign taps_o[k] = g_stage[(k+1)*STAGES_PER_TAP-1].inv_out;
  end

endmodule

// File: rtl/delay_tdc_sensor.sv
// Delay-line TDC sensor: launches an edge into the kept inverter chain,
// captures how far it travelled in one clock, encodes the run length and
// accumulates it over num_samples launches.
// Optional bubble detection is built when TDC_BUBBLE_CHECK_EN is defined.
//
// state     | meaning
// ----------+--------------------------------------------------------
// S_IDLE    | waiting for start; accum/tap_count hold last result
// S_LAUNCH  | toggle launch register, edge enters the delay line
// S_CAPTURE | register taps, polarity-corrected so "arrived" = 1
// S_ENCODE  | count contiguous 1s from tap 0 into tap_count
// S_ACCUM   | saturating add into accum, bump sample counter
// S_DONE    | one-cycle done pulse, back to idle
module delay_tdc_sensor
  import delay_tdc_pkg::*;
#(
  parameter int NUM_TAPS       = 64,
  parameter int STAGES_PER_TAP = 2,
  parameter int ACC_W          = 20
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [7:0]                      num_samples,
  output logic                            busy,
  output logic                            done,
  output logic [$clog2(NUM_TAPS+1)-1:0]   tap_count,
  output logic [ACC_W-1:0]                accum,
  output logic                            bubble_err
);

  localparam int CNT_W = $clog2(NUM_TAPS+1);

  if (!stages_are_even(STAGES_PER_TAP)) begin : g_bad_stages
    $error("delay_tdc_sensor: STAGES_PER_TAP must be a positive even number");
  end

  tdc_state_e           state_q, state_d;
  logic                 launch_q, launch_d;
  logic [NUM_TAPS-1:0]  sample_q, sample_d;
  logic [CNT_W-1:0]     tap_count_q, tap_count_d;
  logic [ACC_W-1:0]     accum_q, accum_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [7:0]           n_q, n_d;

  logic [NUM_TAPS-1:0]  taps;
  logic [NUM_TAPS-1:0]  arrived;
  logic [CNT_W-1:0]     run_len;
  logic                 run_open;
  logic [ACC_W:0]       acc_sum;
  logic [8:0]           cnt_next;
`ifdef TDC_BUBBLE_CHECK_EN
  logic                 bubble_q, bubble_d, bubble_hit;
`endif

  tdc_delay_line #(
    .NUM_TAPS       (NUM_TAPS),
    .STAGES_PER_TAP (STAGES_PER_TAP)
  ) u_line (
    .launch_i (launch_q),
    .taps_o   (taps)
  );

  // A tap that has caught up with the launch level reads 1.
  assign arrived  = taps ^ {NUM_TAPS{~launch_q}};
  assign acc_sum  = {1'b0, accum_q} + (ACC_W+1)'(tap_count_q);
  assign cnt_next = {1'b0, cnt_q} + 9'd1;

  // Thermometer run length from tap 0; anything after the first 0 is a bubble.
  always_comb begin
    run_len  = '0;
    run_open = 1'b1;
`ifdef TDC_BUBBLE_CHECK_EN
    bubble_hit = 1'b0;
`endif
    for (int i = 0; i < NUM_TAPS; i++) begin
      if (run_open) begin
        if (sample_q[i]) run_len = run_len + CNT_W'(1);
        else             run_open = 1'b0;
      end
`ifdef TDC_BUBBLE_CHECK_EN
      else if (sample_q[i]) bubble_hit = 1'b1;
`endif
    end
  end

  // Next-state and datapath updates for the measurement sequence.
  always_comb begin
    state_d     = state_q;
    launch_d    = launch_q;
    sample_d    = sample_q;
    tap_count_d = tap_count_q;
    accum_d     = accum_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LAUNCH;
          accum_d = '0;
          cnt_d   = '0;
          n_d     = (num_samples == 8'd0) ? 8'd1 : num_samples;
        end
      end
      S_LAUNCH: begin
        launch_d = ~launch_q;
        state_d  = S_CAPTURE;
      end
      S_CAPTURE: begin
        sample_d = arrived;
        state_d  = S_ENCODE;
      end
      S_ENCODE: begin
        tap_count_d = run_len;
        state_d     = S_ACCUM;
      end
      S_ACCUM: begin
        accum_d = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
        cnt_d   = cnt_next[7:0];
        state_d = (cnt_next < {1'b0, n_q}) ? S_LAUNCH : S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      launch_q    <= 1'b0;
      sample_q    <= '0;
      tap_count_q <= '0;
      accum_q     <= '0;
      cnt_q       <= '0;
      n_q         <= '0;
    end else begin
      state_q     <= state_d;
      launch_q    <= launch_d;
      sample_q    <= sample_d;
      tap_count_q <= tap_count_d;
      accum_q     <= accum_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
    end
  end

`ifdef TDC_BUBBLE_CHECK_EN
  // Sticky bubble flag: cleared by an accepted start, set by a bad capture.
  always_comb begin
    bubble_d = bubble_q;
    if (state_q == S_IDLE && start)                bubble_d = 1'b0;
    else if (state_q == S_ENCODE && bubble_hit)    bubble_d = 1'b1;
  end

  // Bubble flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bubble_q <= 1'b0;
    else        bubble_q <= bubble_d;
  end

  assign bubble_err = bubble_q;
`else
  assign bubble_err = 1'b0;
`endif

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign tap_count = tap_count_q;
  assign accum     = accum_q;

endmodule

// File: tb/tb_delay_tdc_sensor.sv
// Directed bench for delay_tdc_sensor. The captured tap vector is forced so
// each scenario has a known run length. Bubble expectations follow
// TDC_BUBBLE_CHECK_EN.
module tb_delay_tdc_sensor;

`ifdef TDC_BUBBLE_CHECK_EN
  localparam logic EXP_BUB = 1'b1;
`else
  localparam logic EXP_BUB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  num_samples = 8'd0;
  logic        busy, done, bubble_err;
  logic [6:0]  tap_count;
  logic [19:0] accum;

  logic        start8 = 1'b0;
  logic [7:0]  ns8 = 8'd0;
  logic        busy8, done8, bub8;
  logic [6:0]  tc8;
  logic [7:0]  acc8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  delay_tdc_sensor dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .busy(busy), .done(done), .tap_count(tap_count), .accum(accum),
    .bubble_err(bubble_err)
  );

  delay_tdc_sensor #(.ACC_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .num_samples(ns8),
    .busy(busy8), .done(done8), .tap_count(tc8), .accum(acc8),
    .bubble_err(bub8)
  );

  // Runs one measurement on dut; cycle j counts from the start-accept edge.
  task automatic run_meas(input logic [7:0] n, input int window,
                          input int pulse_a, input int pulse_b,
                          output int done_cnt, output int done_at,
                          output int busy_first, output int busy_last);
    @(negedge clk);
    num_samples = n;
    start = 1'b1;
    @(posedge clk);
    done_cnt = 0; done_at = -1; busy_first = -1; busy_last = -1;
    for (int j = 1; j <= window; j++) begin
      @(negedge clk);
      start = (j == pulse_a) || (j == pulse_b);
      if (busy) begin
        if (busy_first < 0) busy_first = j;
        busy_last = j;
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = j;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b want 0", done); end
    n_cmp++; if (tap_count !== 7'd0) begin n_err++; $display("FAIL reset_tap_count: got %0d want 0", tap_count); end
    n_cmp++; if (accum !== 20'd0) begin n_err++; $display("FAIL reset_accum: got %0d want 0", accum); end
    n_cmp++; if (bubble_err !== 1'b0) begin n_err++; $display("FAIL reset_bubble: got %0b want 0", bubble_err); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_16();
    int dc, da, bf, bl;
    force dut.arrived = 64'h0000_0000_0000_FFFF;
    run_meas(8'd1, 8, 0, 0, dc, da, bf, bl);
    n_cmp++; if (da !== 5) begin n_err++; $display("FAIL s16_done_at: got %0d want 5", da); end
    n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL s16_done_count: got %0d want 1", dc); end
    n_cmp++; if (bf !== 1 || bl !== 5) begin n_err++; $display("FAIL s16_busy_window: got %0d..%0d want 1..5", bf, bl); end
    n_cmp++; if (tap_count !== 7'd16) begin n_err++; $display("FAIL s16_tap_count: got %0d want 16", tap_count); end
    n_cmp++; if (accum !== 20'd16) begin n_err++; $display("FAIL s16_accum: got %0d want 16", accum); end
    repeat (4) @(negedge clk);
    n_cmp++; if (accum !== 20'd16 || tap_count !== 7'd16) begin n_err++; $display("FAIL s16_idle_hold: got accum %0d tap %0d want 16 16", accum, tap_count); end
    n_cmp++; if (bubble_err !== 1'b0) begin n_err++; $display("FAIL s16_bubble: got %0b want 0", bubble_err); end
    release dut.arrived;
  endtask

  task automatic test_multi_24();
    int dc, da, bf, bl;
    force dut.arrived = 64'h0000_0000_00FF_FFFF;
    run_meas(8'd4, 22, 0, 0, dc, da, bf, bl);
    n_cmp++; if (da !== 17) begin n_err++; $display("FAIL m24_done_at: got %0d want 17", da); end
    n_cmp++; if (bf !== 1 || bl !== 17) begin n_err++; $display("FAIL m24_busy_window: got %0d..%0d want 1..17", bf, bl); end
    n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL m24_done_count: got %0d want 1", dc); end
    n_cmp++; if (accum !== 20'd96) begin n_err++; $display("FAIL m24_accum: got %0d want 96", accum); end
    n_cmp++; if (tap_count !== 7'd24) begin n_err++; $display("FAIL m24_tap_count: got %0d want 24", tap_count); end
    release dut.arrived;
  endtask

  task automatic test_all_ones();
    int dc, da, bf, bl;
    force dut.arrived = {64{1'b1}};
    run_meas(8'd2, 12, 0, 0, dc, da, bf, bl);
    n_cmp++; if (tap_count !== 7'd64) begin n_err++; $display("FAIL ones_tap_count: got %0d want 64", tap_count); end
    n_cmp++; if (accum !== 20'd128) begin n_err++; $display("FAIL ones_accum: got %0d want 128", accum); end
    n_cmp++; if (da !== 9) begin n_err++; $display("FAIL ones_done_at: got %0d want 9", da); end
    release dut.arrived;
  endtask

  task automatic test_saturation();
    int da;
    force dut8.arrived = {64{1'b1}};
    @(negedge clk);
    ns8 = 8'd5;
    start8 = 1'b1;
    @(posedge clk);
    da = -1;
    for (int j = 1; j <= 26; j++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (done8 && da < 0) da = j;
    end
    n_cmp++; if (acc8 !== 8'd255) begin n_err++; $display("FAIL sat_accum: got %0d want 255", acc8); end
    n_cmp++; if (da !== 21) begin n_err++; $display("FAIL sat_done_at: got %0d want 21", da); end
    n_cmp++; if (tc8 !== 7'd64) begin n_err++; $display("FAIL sat_tap_count: got %0d want 64", tc8); end
    release dut8.arrived;
  endtask

  task automatic test_bubble();
    int dc, da, bf, bl;
    force dut.arrived = 64'h0000_0000_0000_0F0F;
    run_meas(8'd1, 8, 0, 0, dc, da, bf, bl);
    n_cmp++; if (tap_count !== 7'd4) begin n_err++; $display("FAIL bub_tap_count: got %0d want 4", tap_count); end
    n_cmp++; if (bubble_err !== EXP_BUB) begin n_err++; $display("FAIL bub_flag: got %0b want %0b", bubble_err, EXP_BUB); end
    repeat (5) @(negedge clk);
    n_cmp++; if (bubble_err !== EXP_BUB) begin n_err++; $display("FAIL bub_sticky: got %0b want %0b", bubble_err, EXP_BUB); end
    force dut.arrived = 64'h0000_0000_0000_00FF;
    run_meas(8'd1, 8, 0, 0, dc, da, bf, bl);
    n_cmp++; if (bubble_err !== 1'b0) begin n_err++; $display("FAIL bub_cleared: got %0b want 0", bubble_err); end
    n_cmp++; if (tap_count !== 7'd8) begin n_err++; $display("FAIL bub_clean_tap: got %0d want 8", tap_count); end
    force dut.arrived = 64'hFFFF_FFFF_FFFF_FFFE;
    run_meas(8'd1, 8, 0, 0, dc, da, bf, bl);
    n_cmp++; if (tap_count !== 7'd0) begin n_err++; $display("FAIL tap0_zero_count: got %0d want 0", tap_count); end
    n_cmp++; if (accum !== 20'd0) begin n_err++; $display("FAIL tap0_zero_accum: got %0d want 0", accum); end
    n_cmp++; if (bubble_err !== EXP_BUB) begin n_err++; $display("FAIL tap0_zero_bubble: got %0b want %0b", bubble_err, EXP_BUB); end
    release dut.arrived;
  endtask

  task automatic test_back_to_back();
    int dc, da, bf, bl;
    force dut.arrived = 64'h0000_0000_0000_00FF;
    run_meas(8'd2, 14, 3, 9, dc, da, bf, bl);
    n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL b2b_done_count: got %0d want 1", dc); end
    n_cmp++; if (da !== 9) begin n_err++; $display("FAIL b2b_done_at: got %0d want 9", da); end
    n_cmp++; if (bl !== 9) begin n_err++; $display("FAIL b2b_busy_last: got %0d want 9", bl); end
    n_cmp++; if (accum !== 20'd16) begin n_err++; $display("FAIL b2b_accum: got %0d want 16", accum); end
    run_meas(8'd0, 8, 0, 0, dc, da, bf, bl);
    n_cmp++; if (da !== 5) begin n_err++; $display("FAIL ns0_done_at: got %0d want 5", da); end
    n_cmp++; if (accum !== 20'd8) begin n_err++; $display("FAIL ns0_accum: got %0d want 8", accum); end
    release dut.arrived;
  endtask

  task automatic test_reset_mid();
    int dc, da, bf, bl;
    int dseen;
    force dut.arrived = 64'h0000_0000_0000_0003;
    @(negedge clk);
    num_samples = 8'd3;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL mid_rst_ctrl: got busy %0b done %0b want 0 0", busy, done); end
    n_cmp++; if (tap_count !== 7'd0) begin n_err++; $display("FAIL mid_rst_tap: got %0d want 0", tap_count); end
    n_cmp++; if (accum !== 20'd0 || bubble_err !== 1'b0) begin n_err++; $display("FAIL mid_rst_acc_bub: got %0d %0b want 0 0", accum, bubble_err); end
    dseen = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (done) dseen++;
    end
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (done) dseen++;
    end
    n_cmp++; if (dseen !== 0) begin n_err++; $display("FAIL mid_rst_no_done: got %0d pulses want 0", dseen); end
    run_meas(8'd1, 8, 0, 0, dc, da, bf, bl);
    n_cmp++; if (da !== 5 || dc !== 1) begin n_err++; $display("FAIL post_rst_done: got at %0d count %0d want 5 1", da, dc); end
    n_cmp++; if (accum !== 20'd2 || tap_count !== 7'd2) begin n_err++; $display("FAIL post_rst_result: got accum %0d tap %0d want 2 2", accum, tap_count); end
    release dut.arrived;
  endtask

  initial begin
    test_reset();
    test_single_16();
    test_multi_24();
    test_all_ones();
    test_saturation();
    test_bubble();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
